// File: rtl/nway_wb_cache.sv
// N-way set-associative write-back, write-allocate cache with true-LRU replacement.
// One word per line; dirty victims are written back before the refill over a req/response port.
module nway_wb_cache #(
  parameter int WAYS   = 4,
  parameter int SETS   = 256,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_miss,
  output logic              o_evict,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              i_memory_response,
  input  logic [DATA_W-1:0] i_memory_line
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int AGE_W = $clog2(WAYS);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, REFILL, DONE} state_t;

  state_t            state_q;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];

  logic              req_we_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [AGE_W-1:0]  victim_q;

  logic              o_ready_q, o_rvalid_q, o_miss_q, o_evict_q;
  logic              mem_req_q, mem_we_q;
  logic [DATA_W-1:0] o_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              hit_s, any_inv_s, victim_dirty_s;
  logic [AGE_W-1:0]  hit_way_s, inv_way_s, lru_way_s, acc_way_s, victim_d;
  logic [AGE_W-1:0]  age_d [WAYS];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^i_addr[OFF_W-1:0];

  // Tag match, victim choice and move-to-front ages for the addressed set.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    any_inv_s = 1'b0;
    inv_way_s = '0;
    lru_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = (valid_q[req_idx_q][w] && tag_q[req_idx_q][w] == req_tag_q) ? AGE_W'(w) : hit_way_s;
      hit_s     = hit_s | (valid_q[req_idx_q][w] && tag_q[req_idx_q][w] == req_tag_q);
      inv_way_s = !valid_q[req_idx_q][w] ? AGE_W'(w) : inv_way_s;
      any_inv_s = any_inv_s | !valid_q[req_idx_q][w];
      lru_way_s = (age_q[req_idx_q][w] == AGE_MAX) ? AGE_W'(w) : lru_way_s;
    end
    victim_d       = any_inv_s ? inv_way_s : lru_way_s;
    victim_dirty_s = valid_q[req_idx_q][victim_d] & dirty_q[req_idx_q][victim_d];
    acc_way_s      = (state_q == DONE) ? victim_q : hit_way_s;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == acc_way_s) begin
        age_d[w] = '0;
      end else if (age_q[req_idx_q][w] < age_q[req_idx_q][acc_way_s]) begin
        age_d[w] = age_q[req_idx_q][w] + AGE_W'(1);
      end else begin
        age_d[w] = age_q[req_idx_q][w];
      end
    end
  end

  // Controller FSM, registered outputs and the line arrays.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      o_ready_q   <= 1'b1;
      o_rvalid_q  <= 1'b0;
      o_miss_q    <= 1'b0;
      o_evict_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      o_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      o_rvalid_q <= 1'b0;
      o_miss_q   <= 1'b0;
      o_evict_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            req_we_q    <= i_we;
            req_tag_q   <= i_addr[ADDR_W-1 -: TAG_W];
            req_idx_q   <= i_addr[OFF_W +: IDX_W];
            req_wdata_q <= i_wdata;
            o_ready_q   <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            if (req_we_q) begin
              data_q[req_idx_q][hit_way_s]  <= req_wdata_q;
              dirty_q[req_idx_q][hit_way_s] <= 1'b1;
            end else begin
              o_rdata_q <= data_q[req_idx_q][hit_way_s];
            end
            for (int w = 0; w < WAYS; w++) age_q[req_idx_q][w] <= age_d[w];
            o_rvalid_q <= 1'b1;
            o_ready_q  <= 1'b1;
            state_q    <= IDLE;
          end else begin
            victim_q  <= victim_d;
            o_miss_q  <= 1'b1;
            mem_req_q <= 1'b1;
            if (victim_dirty_s) begin
              o_evict_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx_q][victim_d], req_idx_q, {OFF_W{1'b0}}};
              mem_wdata_q <= data_q[req_idx_q][victim_d];
              state_q     <= EVICT;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
              state_q    <= REFILL;
            end
          end
        end
        EVICT: begin
          // mem_req stays high; the transfer simply turns into the refill read.
          if (i_memory_response) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          if (i_memory_response) begin
            data_q[req_idx_q][victim_q]  <= i_memory_line;
            tag_q[req_idx_q][victim_q]   <= req_tag_q;
            valid_q[req_idx_q][victim_q] <= 1'b1;
            dirty_q[req_idx_q][victim_q] <= 1'b0;
            mem_req_q                    <= 1'b0;
            state_q                      <= DONE;
          end
        end
        DONE: begin
          if (req_we_q) begin
            data_q[req_idx_q][victim_q]  <= req_wdata_q;
            dirty_q[req_idx_q][victim_q] <= 1'b1;
          end else begin
            o_rdata_q <= data_q[req_idx_q][victim_q];
          end
          for (int w = 0; w < WAYS; w++) age_q[req_idx_q][w] <= age_d[w];
          o_rvalid_q <= 1'b1;
          o_ready_q  <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          o_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign o_ready   = o_ready_q;
  assign o_rdata   = o_rdata_q;
  assign o_rvalid  = o_rvalid_q;
  assign o_miss    = o_miss_q;
  assign o_evict   = o_evict_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: doc/nway_wb_cache.md
# nway_wb_cache

Parametrised N-way set-associative write-back, write-allocate cache with true-LRU replacement. It sits between the core load/store port and the memory line port and supersedes the fixed 4-way `sa_cache`. Ways, sets, address and data width are generic. Dirty victims are evicted to memory before the refill, over a req/response handshake. One word per line.

## Interface
- `WAYS`, 4, associativity; power of 2, ≥2
- `SETS`, 256, sets; power of 2
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word/line width; multiple of 8
- Derived: `OFF_W`=log2(DATA_W/8), `IDX_W`=log2(SETS), `TAG_W`=ADDR_W-IDX_W-OFF_W; address = {tag, index, offset}, offset ignored

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  core request valid
- `i_we`  in  1  1 = write, 0 = read
- `i_addr`  in  ADDR_W  byte address
- `i_wdata`  in  DATA_W  write data
- `o_ready`  out  1  cache idle; request accepted when `i_req & o_ready`
- `o_rdata`  out  DATA_W  read data, valid with `o_rvalid`
- `o_rvalid`  out  1  one-cycle completion pulse (reads and writes)
- `o_miss`  out  1  one-cycle miss pulse
- `o_evict`  out  1  one-cycle pulse when a dirty victim is selected
- `mem_req`  out  1  memory request, held until response
- `mem_we`  out  1  1 = eviction write, 0 = refill read
- `mem_addr`  out  ADDR_W  line address, offset bits zero
- `mem_wdata`  out  DATA_W  evicted line data
- `i_memory_response`  in  1  memory done; sampled only while `mem_req`=1
- `i_memory_line`  in  DATA_W  refill data, valid with response on a read

## Operation
- Per way and set: valid, dirty, tag, data. Per set: WAYS age counters of log2(WAYS) bits, where 0 = MRU.
- FSM states: IDLE, LOOKUP, EVICT, REFILL, DONE.
- IDLE: `o_ready`=1. On accept, register addr, we and wdata, then go to LOOKUP. `i_req` while not ready is ignored; requests are not queued.
- LOOKUP, hit (valid & tag match): read drives `o_rdata`; write updates data and sets dirty. Update LRU, pulse `o_rvalid`, go to IDLE.
- LOOKUP, miss: pulse `o_miss`.
  - Victim selection: lowest-index invalid way, otherwise the way with age = WAYS-1.
  - Victim valid & dirty: pulse `o_evict`, go to EVICT.
  - Otherwise: go to REFILL.
- EVICT: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 0}, `mem_wdata`=victim data. On response, go to REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={req tag, index, 0}. On response, write `i_memory_line` into the victim way with valid=1, dirty=0, tag updated, then go to DONE.
- DONE: perform the pending read or write on the filled way as on a hit. Update LRU, pulse `o_rvalid`, go to IDLE.
- LRU update on access to way w: every way with age < age[w] increments; age[w] becomes 0. Ages remain a permutation of 0..WAYS-1.

## Timing
- Reset values:
  - FSM in IDLE.
  - Outputs: `o_ready`=1; `o_rvalid`, `o_miss`, `o_evict`, `mem_req`, `mem_we` = 0; `o_rdata`, `mem_addr`, `mem_wdata` = 0.
  - All valid and dirty bits = 0; set ages = way index. Data and tag arrays are not reset.
- Hit latency: request accepted at edge E0, LOOKUP occupies cycle E0→E1, `o_rvalid` is high in cycle E1→E2. `o_ready` returns high in that same cycle. Peak rate is one request per 2 cycles.
- `o_miss` and `o_evict` are high in the first cycle of EVICT or REFILL.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stable while `mem_req`=1.
  - A response in any cycle with `mem_req`=1, including the first, completes that transfer at that edge.
  - Between EVICT and REFILL, `mem_req` drops for ≥0 cycles; it may stay high with `mem_we` toggling to 0.
- Miss latency: 2 + refill wait + 1, plus eviction wait if the victim is dirty.
- Reset mid-operation: any state goes to IDLE, `mem_req`=0 next cycle, all lines invalidated, and the pending request is dropped with no `o_rvalid`.

## Test plan
Parameters: WAYS=4, SETS=256, 32-bit, giving set = addr[9:2].
- Cold read 0x100 → `o_miss` pulse, REFILL read at 0x100; respond 0xDEADBEEF after 3 cycles → `o_rvalid` with `o_rdata`=0xDEADBEEF. Re-read 0x100 → hit, no `mem_req`, `o_rvalid` 2 edges after accept.
- Write 0x12345678 to 0x100 (hit) → no memory traffic. Read 0x100 → 0x12345678.
- Reads 0x500, 0x900, 0xD00 fill set 0x40 with no eviction. Then read 0x1100 → victim is 0x100 (LRU, dirty): `o_evict`, EVICT write addr 0x100 data 0x12345678, then REFILL read 0x1100.
- LRU order: after the fill, touch 0x500, then access 0x1500 → victim 0x900 (clean), no EVICT, no `o_evict`.
- `rst` while REFILL `mem_req`=1 → next cycle `mem_req`=0, `o_ready`=1, no `o_rvalid`. Subsequent read of 0x500 misses.
- `i_req` pulsed during REFILL and `i_memory_response` pulsed in IDLE → both ignored; state, arrays and outputs unchanged.
